uart_tx_queue: RTL and testbench

//   Transmit byte queue between the io block and the uart transmitter.
//   - Upstream: io writes bytes with single-cycle push strobes.
//   - Downstream: drains one byte at a time into the uart via tx_data/tx_wr.
//   - Waits for tx_done before launching the next byte.
//   - Lets software fire bursts of bytes without polling the uart per byte.
//   - Clocked by the uart's clock; all inputs are synchronous to clk.

---
 rtl/uart_tx_queue.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding a uart transmitter.
// Bytes pushed by the io block are held in a circular buffer and handed to
// the uart one at a time. The next byte is launched only after the uart
// reports that the previous one has been fully sent.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic [WIDTH-1:0]      tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      DATA_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [WIDTH-1:0]        mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_r;
    logic [DEPTH_LOG2-1:0]   rptr_r;
    logic [DEPTH_LOG2:0]     count_r;
    logic [DEPTH_LOG2:0]     count_next_s;
    logic                    full_r;
    logic                    overflow_r;
    logic [WIDTH-1:0]        tx_data_r;
    logic                    tx_wr_r;
    logic                    busy_r;
    logic                    accept_s;
    logic                    drop_s;
    logic                    pop_s;

    // Push acceptance uses the registered full flag, so a pop in the same
    // cycle does not rescue a push made against a full queue.
    assign accept_s = push & ~full_r;
    assign drop_s   = push & full_r;

    // Next-state and pop decision for the launch sequencer.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != CNT_ZERO) begin
                    state_next_s = LOAD;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's accepted push and pop.
    always_comb begin
        count_next_s = count_r;
        if (accept_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!accept_s && pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read/write pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
        end
    end

    // Queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rst && accept_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Sticky overflow; a dropped push beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Uart-facing outputs, registered from the next state so tx_wr is high
    // exactly while the sequencer sits in LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_data_r <= DATA_ZERO;
            tx_wr_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (pop_s) begin
                tx_data_r <= mem_r[rptr_r];
            end
            tx_wr_r <= (state_next_s == LOAD);
            busy_r  <= (state_next_s != IDLE);
        end
    end

    assign full     = full_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_wr    = tx_wr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a scoreboard of pushed bytes is
// compared against every tx_wr pulse; a small uart model answers with tx_done.
module tb_uart_tx_queue;

    logic        clk;
    logic        rst;
    logic        push;
    logic [7:0]  push_data;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        clear_ovf;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr = 0;
    int          cyc = 0;
    int          done_at = -1;
    int          done_delay = 20;
    int          done_cyc = 0;
    bit          auto_done = 1'b0;
    bit          man_done = 1'b0;
    bit          gap_pending = 1'b0;
    logic        prev_wr = 1'b0;
    logic [7:0]  sb [$];

    uart_tx_queue #(
        .DEPTH_LOG2 (4),
        .WIDTH      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observes outputs on the falling edge; scoreboard and timing checks.
    task automatic monitor();
        logic [7:0] exp_b;
        if (tx_wr === 1'b1) begin
            check_eq("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
            check_eq("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check_eq("tx_data_order", {24'd0, tx_data}, {24'd0, exp_b});
            end
            if (gap_pending) begin
                check_eq("done_to_wr_gap", 32'(cyc - done_cyc), 32'd2);
                gap_pending = 1'b0;
            end
            done_at = cyc + done_delay;
            n_wr++;
        end
        if (tx_done === 1'b1 && busy === 1'b1 && sb.size() != 0) begin
            gap_pending = 1'b1;
            done_cyc = cyc;
        end
        prev_wr = tx_wr;
    endtask

    // One clock: uart model drives tx_done after the rising edge, outputs
    // are sampled on the falling edge, and stimulus resumes from there.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if ((auto_done && done_at == cyc) || man_done) begin
            tx_done = 1'b1;
            man_done = 1'b0;
        end else begin
            tx_done = 1'b0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic push_byte(input logic [7:0] b, input bit kept);
        push = 1'b1;
        push_data = b;
        if (kept) begin
            sb.push_back(b);
        end
        step();
        push = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int left;
        left = budget;
        while (left > 0 && (sb.size() != 0 || busy !== 1'b0)) begin
            step();
            left--;
        end
        check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n0;
        int left;
        rst = 1'b0;
        push = 1'b0;
        push_data = 8'h00;
        clear_ovf = 1'b0;
        tx_done = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        check_eq("rst_count", {27'd0, count}, 32'd0);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        check_eq("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b1;
        step();

        // Single byte: launch latency and busy window.
        auto_done = 1'b1;
        done_delay = 5;
        push_byte(8'h41, 1'b1);
        check_eq("single_count_after_push", {27'd0, count}, 32'd1);
        check_eq("single_no_wr_yet", {31'd0, tx_wr}, 32'd0);
        step();
        check_eq("single_wr", {31'd0, tx_wr}, 32'd1);
        check_eq("single_data", {24'd0, tx_data}, 32'h41);
        check_eq("single_count_after_pop", {27'd0, count}, 32'd0);
        left = 50;
        while (left > 0 && tx_done !== 1'b1) begin
            check_eq("single_busy_until_done", {31'd0, busy}, 32'd1);
            step();
            left--;
        end
        check_eq("single_done_seen", {31'd0, tx_done}, 32'd1);
        check_eq("single_busy_at_done", {31'd0, busy}, 32'd1);
        step();
        check_eq("single_busy_dropped", {31'd0, busy}, 32'd0);

        // Burst of sixteen bytes, uart answers 20 cycles after each launch.
        done_delay = 20;
        n0 = n_wr;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i), 1'b1);
        end
        wait_drain(700);
        check_eq("burst_pulses", 32'(n_wr - n0), 32'd16);
        check_eq("burst_count_zero", {27'd0, count}, 32'd0);

        // Overflow: byte in flight, queue filled, one extra push dropped.
        auto_done = 1'b0;
        push_byte(8'hB0, 1'b1);
        step();
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'hC0 + 8'(i), 1'b1);
        end
        check_eq("ovf_count_16", {27'd0, count}, 32'd16);
        check_eq("ovf_full", {31'd0, full}, 32'd1);
        check_eq("ovf_not_yet", {31'd0, overflow}, 32'd0);
        push_byte(8'hAA, 1'b0);
        check_eq("ovf_set", {31'd0, overflow}, 32'd1);
        check_eq("ovf_count_held", {27'd0, count}, 32'd16);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
        clear_ovf = 1'b1;
        push_byte(8'hAB, 1'b0);
        clear_ovf = 1'b0;
        check_eq("ovf_set_wins", {31'd0, overflow}, 32'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check_eq("ovf_cleared_again", {31'd0, overflow}, 32'd0);
        auto_done = 1'b1;
        done_delay = 3;
        man_done = 1'b1;
        wait_drain(400);
        check_eq("ovf_drained_count", {27'd0, count}, 32'd0);
        check_eq("ovf_drained_full", {31'd0, full}, 32'd0);

        // Push coincident with a pop at count 3 keeps count at 3.
        auto_done = 1'b0;
        push_byte(8'h60, 1'b1);
        step();
        step();
        step();
        push_byte(8'h61, 1'b1);
        push_byte(8'h62, 1'b1);
        push_byte(8'h63, 1'b1);
        check_eq("sim_count_3", {27'd0, count}, 32'd3);
        check_eq("sim_busy_wait", {31'd0, busy}, 32'd1);
        man_done = 1'b1;
        step();
        step();
        check_eq("sim_idle", {31'd0, busy}, 32'd0);
        check_eq("sim_count_idle", {27'd0, count}, 32'd3);
        auto_done = 1'b1;
        done_delay = 4;
        push_byte(8'h55, 1'b1);
        check_eq("sim_count_unchanged", {27'd0, count}, 32'd3);
        check_eq("sim_wr", {31'd0, tx_wr}, 32'd1);
        wait_drain(200);

        // Reset while a byte is in flight with five queued behind it.
        auto_done = 1'b0;
        push_byte(8'h70, 1'b1);
        step();
        step();
        step();
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'h70 + 8'(i), 1'b1);
        end
        check_eq("mid_count_5", {27'd0, count}, 32'd5);
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb.delete();
        gap_pending = 1'b0;
        check_eq("mid_rst_count", {27'd0, count}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        check_eq("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        n0 = n_wr;
        man_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check_eq("mid_no_wr_after", 32'(n_wr - n0), 32'd0);
        check_eq("mid_still_idle", {31'd0, busy}, 32'd0);
        check_eq("mid_still_empty", {27'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
